// File: rtl/rns_pkg.sv
// rtl/rns_pkg.sv - shared RNS thermometer-code helpers
package rns_pkg;

  localparam int MOD_DEFAULT = 7;
  localparam int TC_MAXW     = 16;

  typedef logic [TC_MAXW-1:0] tc_word_t;

  // Legal words are 0..01..1: adding one to a run of low ones never overlaps it.
  function automatic logic tc_is_legal(input tc_word_t w);
    return (w & (w + tc_word_t'(1))) == '0;
  endfunction

  function automatic int tc_popcount(input tc_word_t w);
    int n;
    n = 0;
    for (int i = 0; i < TC_MAXW; i++) n += int'(w[i]);
    return n;
  endfunction

  function automatic tc_word_t bin_to_tc(input int v);
    return (tc_word_t'(1) << v) - tc_word_t'(1);
  endfunction

endpackage

// File: rtl/tc_mod_adder_pipe_if.sv
// rtl/tc_mod_adder_pipe_if.sv - operand/result handshake bundle for the TC modular adder
interface tc_mod_adder_pipe_if
  import rns_pkg::*;
#(
  parameter int MOD = MOD_DEFAULT,
  parameter int TW  = MOD - 1,
  parameter int BW  = $clog2(MOD)
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a_tc;
  logic [TW-1:0] b_tc;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum_tc;
  logic [BW-1:0] sum_bin;
  logic          sum_err;

  modport master (
    output in_valid, a_tc, b_tc, out_ready,
    input  in_ready, out_valid, sum_tc, sum_bin, sum_err
  );

  modport slave (
    input  in_valid, a_tc, b_tc, out_ready,
    output in_ready, out_valid, sum_tc, sum_bin, sum_err
  );
endinterface

// File: rtl/tc_mod_add_core.sv
// rtl/tc_mod_add_core.sv - combinational TC residue adder, counts ones instead of adding
module tc_mod_add_core
  import rns_pkg::*;
#(
  parameter int MOD = MOD_DEFAULT,
  parameter int TW  = MOD - 1,
  parameter int BW  = $clog2(MOD)
) (
  input  logic [TW-1:0] a_tc,
  input  logic [TW-1:0] b_tc,
  output logic [TW-1:0] sum_tc,
  output logic [BW-1:0] sum_bin,
  output logic          err
);

  tc_word_t a_w, b_w, full_tc;
  int       s;

  always_comb begin
    a_w     = tc_word_t'(a_tc);
    b_w     = tc_word_t'(b_tc);
    s       = tc_popcount(a_w) + tc_popcount(b_w);
    // one conditional subtract suffices since s <= 2*(MOD-1)
    if (s >= MOD) s = s - MOD;
    err     = !(tc_is_legal(a_w) && tc_is_legal(b_w));
    full_tc = bin_to_tc(s);
    if (err) begin
      sum_tc  = '0;
      sum_bin = '0;
    end else begin
      sum_tc  = full_tc[TW-1:0];
      sum_bin = BW'(s);
    end
  end

endmodule

// File: rtl/tc_mod_adder_pipe.sv
// rtl/tc_mod_adder_pipe.sv - 2-stage valid/ready pipeline adding TC residues mod MOD
module tc_mod_adder_pipe
  import rns_pkg::*;
#(
  parameter int MOD = MOD_DEFAULT,
  parameter int TW  = MOD - 1,
  parameter int BW  = $clog2(MOD)
) (
  input  logic                clk,
  input  logic                rst_n,
  tc_mod_adder_pipe_if.slave  bus,
  input  logic                clr_err,
  output logic                err_sticky
);

  logic          s1_valid, s1_legal;
  logic [TW-1:0] s1_a, s1_b;
  logic          s2_valid, s2_err;
  logic [TW-1:0] s2_tc;
  logic [BW-1:0] s2_bin;
  logic          s1_adv, in_ready, in_fire, in_legal;
  logic [TW-1:0] core_tc;
  logic [BW-1:0] core_bin;
  logic          core_err;

  assign s1_adv   = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = bus.in_valid && in_ready;
  assign in_legal = tc_is_legal(tc_word_t'(bus.a_tc)) && tc_is_legal(tc_word_t'(bus.b_tc));

  tc_mod_add_core #(.MOD(MOD), .TW(TW), .BW(BW)) u_core (
    .a_tc    (s1_a),
    .b_tc    (s1_b),
    .sum_tc  (core_tc),
    .sum_bin (core_bin),
    .err     (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_legal   <= 1'b1;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_tc      <= '0;
      s2_bin     <= '0;
      s2_err     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_a     <= bus.a_tc;
        s1_b     <= bus.b_tc;
        s1_legal <= in_legal;
      end
      // result registers only move when the consumer side frees up
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_tc  <= core_tc;
          s2_bin <= core_bin;
          s2_err <= core_err || !s1_legal;
        end
      end
      if (in_fire && !in_legal) err_sticky <= 1'b1;
      else if (clr_err)         err_sticky <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.sum_tc    = s2_tc;
  assign bus.sum_bin   = s2_bin;
  assign bus.sum_err   = s2_err;

endmodule

// File: tb/tb_tc_mod_adder_pipe.sv
// tb/tb_tc_mod_adder_pipe.sv - directed and randomized bench for tc_mod_adder_pipe
module tb_tc_mod_adder_pipe;
  import rns_pkg::*;

  localparam int MOD = 7;
  localparam int TW  = 6;
  localparam int BW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_err = 1'b0;
  logic err_sticky;

  tc_mod_adder_pipe_if #(.MOD(MOD)) bus();

  tc_mod_adder_pipe #(.MOD(MOD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_err    (clr_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [TW-1:0] tc;
    logic [BW-1:0] bin;
    logic          err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] tc_of(input int v);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < v; i++) t[i] = 1'b1;
    return t;
  endfunction

  // Applies one operand pair with out_ready=1, returns result and edges-to-valid.
  task automatic do_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                       output logic [TW-1:0] tc, output logic [BW-1:0] bin,
                       output logic err, output int lat);
    logic rdy;
    logic acc;
    acc = 1'b0;
    lat = -1;
    bus.out_ready = 1'b1;
    bus.a_tc = a;
    bus.b_tc = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = 1'b1;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        lat = i + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    tc  = bus.sum_tc;
    bin = bus.sum_bin;
    err = bus.sum_err;
    if (lat < 0) chk("output_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [TW-1:0] r_tc;
  logic [BW-1:0] r_bin;
  logic          r_err;
  int            r_lat;

  initial begin
    logic rdy, ov;
    int   idx;
    int   bp_exp[4];
    int   got[$];
    logic [BW-1:0] sb;

    bus.in_valid  = 1'b0;
    bus.a_tc      = '0;
    bus.b_tc      = '0;
    bus.out_ready = 1'b1;

    vecs.push_back('{6'b000111, 6'b011111, 6'b000001, 3'd1, 1'b0});
    vecs.push_back('{6'b111111, 6'b111111, 6'b011111, 3'd5, 1'b0});
    vecs.push_back('{6'b000011, 6'b011111, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{6'b000000, 6'b000000, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{6'b000001, 6'b000000, 6'b000001, 3'd1, 1'b0});
    vecs.push_back('{6'b000111, 6'b001111, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{6'b111111, 6'b000001, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{6'b001111, 6'b001111, 6'b000001, 3'd1, 1'b0});
    vecs.push_back('{6'b000011, 6'b000111, 6'b011111, 3'd5, 1'b0});
    vecs.push_back('{6'b111111, 6'b000000, 6'b111111, 3'd6, 1'b0});
    vecs.push_back('{6'b000101, 6'b000001, 6'b000000, 3'd0, 1'b1});
    vecs.push_back('{6'b000001, 6'b011011, 6'b000000, 3'd0, 1'b1});

    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum_tc", bus.sum_tc, 0);
    chk("rst_sum_bin", bus.sum_bin, 0);
    chk("rst_sum_err", bus.sum_err, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, r_tc, r_bin, r_err, r_lat);
      chk($sformatf("vec%0d_tc", i), r_tc, vecs[i].tc);
      chk($sformatf("vec%0d_bin", i), r_bin, vecs[i].bin);
      chk($sformatf("vec%0d_err", i), r_err, vecs[i].err);
      chk($sformatf("vec%0d_lat", i), r_lat, 2);
    end
    chk("sticky_after_illegal", err_sticky, 1);

    for (int i = 0; i < 10; i++) begin
      do_op(tc_of(i % 7), tc_of(1), r_tc, r_bin, r_err, r_lat);
      chk($sformatf("sticky_hold%0d", i), err_sticky, 1);
    end
    @(negedge clk) clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("sticky_cleared", err_sticky, 0);

    @(negedge clk);
    clr_err = 1'b1;
    bus.a_tc = 6'b000101;
    bus.b_tc = 6'b000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    bus.in_valid = 1'b0;
    chk("sticky_set_wins", err_sticky, 1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk) clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("sticky_recleared", err_sticky, 0);

    // backpressure: four ops with consumer stalled
    bp_exp = '{2, 4, 6, 1};
    bus.out_ready = 1'b0;
    idx = 0;
    bus.a_tc = tc_of(1);
    bus.b_tc = tc_of(1);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      if (bus.out_valid) chk($sformatf("stall_hold%0d", c), bus.sum_bin, 2);
      @(posedge clk);
      #1;
      if (rdy && bus.in_valid) begin
        idx++;
        if (idx < 4) begin
          bus.a_tc = tc_of(idx + 1);
          bus.b_tc = tc_of(idx + 1);
        end else bus.in_valid = 1'b0;
      end
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_hold_bin", bus.sum_bin, 2);
    chk("bp_hold_tc", bus.sum_tc, 6'b000011);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      ov  = bus.out_valid;
      sb  = bus.sum_bin;
      @(posedge clk);
      #1;
      if (ov) got.push_back(int'(sb));
      if (rdy && bus.in_valid) begin
        idx++;
        if (idx < 4) begin
          bus.a_tc = tc_of(idx + 1);
          bus.b_tc = tc_of(idx + 1);
        end else bus.in_valid = 1'b0;
      end
    end
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : -1, bp_exp[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_dup", bus.out_valid, 0);

    begin : rand_test
      int exp_q[$];
      int rcv;
      bit prod_done;
      rcv = 0;
      prod_done = 0;
      fork
        begin
          for (int k = 0; k < 1000; k++) begin
            int va, vb, w;
            logic acc, v;
            va = $urandom_range(0, 6);
            vb = $urandom_range(0, 6);
            bus.a_tc = tc_of(va);
            bus.b_tc = tc_of(vb);
            bus.in_valid = ($urandom_range(0, 2) != 0);
            acc = 1'b0;
            w = 0;
            while (!acc && w < 60) begin
              @(negedge clk);
              rdy = bus.in_ready;
              v = bus.in_valid;
              @(posedge clk);
              #1;
              if (v && rdy) begin
                acc = 1'b1;
                exp_q.push_back((va + vb) % 7);
              end else bus.in_valid = ($urandom_range(0, 1) == 1);
              w++;
            end
            if (!acc) begin
              chk("rand_accept_timeout", 32'd0, 32'd1);
              break;
            end
          end
          bus.in_valid = 1'b0;
          prod_done = 1;
        end
        begin
          int cyc;
          tc_word_t ref_tc;
          cyc = 0;
          while (rcv < 1000 && cyc < 20000) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
              int e;
              if (exp_q.size() == 0) begin
                chk("rand_unexpected_out", 32'd1, 32'd0);
                e = -1;
              end else e = exp_q.pop_front();
              ref_tc = bin_to_tc(int'(bus.sum_bin));
              chk("rand_bin", bus.sum_bin, e);
              chk("rand_tc", bus.sum_tc, tc_of(e));
              chk("rand_tc_vs_bin", bus.sum_tc, ref_tc[TW-1:0]);
              rcv++;
            end
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cyc++;
          end
        end
      join
      chk("rand_count", rcv, 1000);
      chk("rand_prod_done", prod_done, 1);
    end

    // reset with both stages full
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.a_tc = 6'b000101;
    bus.b_tc = '0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a_tc = tc_of(2);
    bus.b_tc = tc_of(2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_sticky", err_sticky, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_sticky", err_sticky, 0);
    chk("arst_sum_err", bus.sum_err, 0);
    chk("arst_sum_bin", bus.sum_bin, 0);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("no_stale%0d", i), bus.out_valid, 0);
    end
    do_op(tc_of(2), tc_of(3), r_tc, r_bin, r_err, r_lat);
    chk("post_rst_tc", r_tc, 6'b011111);
    chk("post_rst_bin", r_bin, 5);
    chk("post_rst_lat", r_lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
